bloom_filter_insert: RTL

Write-side companion to the Bloom filter lookup. It accepts a (src_ip, dest_ip) pair, hashes each address with the same Jenkins one-at-a-time hash the lookup uses, and sets the two corresponding bits in the shared bit-array BRAM with read-modify-write cycles. It also provides a full-array clear sweep. It sits between the control/config path that programs allowed flows and the BRAM port the lookup reads.

---
 rtl/bloom_filter_insert.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/bloom_filter_insert.sv
// Bloom filter insert engine: hashes (src_ip, dest_ip) and sets both filter bits with
// BRAM read-modify-write, plus a full-array clear sweep. Optional: BLOOM_INSERT_DUP_DETECT_EN.
module bloom_filter_insert #(
  parameter int BIT_ARRAY_SIZE = 1024,
  parameter int WORD_WIDTH     = 32,
  parameter int HASH_WIDTH     = $clog2(BIT_ARRAY_SIZE),
  parameter int ADDR_WIDTH     = $clog2(BIT_ARRAY_SIZE / WORD_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [31:0]           src_ip,
  input  logic [31:0]           dest_ip,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  done,
  output logic                  dup,
  output logic [15:0]           insert_count,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [WORD_WIDTH-1:0] bram_wdata,
  input  logic [WORD_WIDTH-1:0] bram_rdata
);

  localparam int BIT_W = $clog2(WORD_WIDTH);
  localparam int DEPTH = BIT_ARRAY_SIZE / WORD_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  typedef enum logic [3:0] {
    IDLE, HASH, RD_A, WAIT_A, WR_A, RD_B, WAIT_B, WR_B, DONE, CLEAR
  } state_t;

  state_t                state_reg;
  logic [31:0]           src_reg;
  logic [31:0]           dest_reg;
  logic [HASH_WIDTH-1:0] idx_a_reg;
  logic [HASH_WIDTH-1:0] idx_b_reg;
  logic [HASH_WIDTH-1:0] hash_a;
  logic [HASH_WIDTH-1:0] hash_b;
  logic [BIT_W-1:0]      bit_a;
  logic [BIT_W-1:0]      bit_b;
  logic [WORD_WIDTH-1:0] mask_a;
  logic [WORD_WIDTH-1:0] mask_b;
  logic [15:0]           count_inc;
`ifdef BLOOM_INSERT_DUP_DETECT_EN
  logic                  bita_set_reg;
  logic                  bitb_set_reg;
`endif

  // Jenkins one-at-a-time over the four bytes, LSB first; only the index bits are kept.
  function automatic logic [HASH_WIDTH-1:0] jenkins(input logic [31:0] data);
    logic [31:0] h;
    h = 32'd0;
    for (int i = 0; i < 4; i++) begin
      h = h + {24'd0, data[8*i +: 8]};
      h = h + (h << 10);
      h = h ^ (h >> 6);
    end
    h = h + (h << 3);
    h = h ^ (h >> 11);
    h = h + (h << 15);
    return h[HASH_WIDTH-1:0];
  endfunction

  assign hash_a    = jenkins(src_reg);
  assign hash_b    = jenkins(dest_reg);
  assign bit_a     = idx_a_reg[BIT_W-1:0];
  assign bit_b     = idx_b_reg[BIT_W-1:0];
  assign mask_a    = {{(WORD_WIDTH-1){1'b0}}, 1'b1} << bit_a;
  assign mask_b    = {{(WORD_WIDTH-1){1'b0}}, 1'b1} << bit_b;
  assign count_inc = (insert_count == 16'hFFFF) ? insert_count : insert_count + 16'd1;

  // A pending clear masks readiness so a simultaneous insert is never accepted.
  assign ins_ready = rst_n && (state_reg == IDLE) && !clear_req;

`ifndef BLOOM_INSERT_DUP_DETECT_EN
  assign dup = 1'b0;
`endif

  // BRAM controls are registered one state early so they are live during their own state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      src_reg      <= '0;
      dest_reg     <= '0;
      idx_a_reg    <= '0;
      idx_b_reg    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      insert_count <= '0;
      bram_en      <= 1'b0;
      bram_we      <= 1'b0;
      bram_addr    <= '0;
      bram_wdata   <= '0;
`ifdef BLOOM_INSERT_DUP_DETECT_EN
      dup          <= 1'b0;
      bita_set_reg <= 1'b0;
      bitb_set_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef BLOOM_INSERT_DUP_DETECT_EN
      dup  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          bram_en <= 1'b0;
          bram_we <= 1'b0;
          if (clear_req) begin
            state_reg    <= CLEAR;
            busy         <= 1'b1;
            insert_count <= '0;
            bram_en      <= 1'b1;
            bram_we      <= 1'b1;
            bram_addr    <= '0;
            bram_wdata   <= '0;
          end else if (ins_valid) begin
            state_reg <= HASH;
            busy      <= 1'b1;
            src_reg   <= src_ip;
            dest_reg  <= dest_ip;
          end
        end
        HASH: begin
          idx_a_reg <= hash_a;
          idx_b_reg <= hash_b;
          bram_en   <= 1'b1;
          bram_we   <= 1'b0;
          bram_addr <= hash_a[HASH_WIDTH-1:BIT_W];
          state_reg <= RD_A;
        end
        RD_A: begin
          bram_en   <= 1'b0;
          state_reg <= WAIT_A;
        end
        WAIT_A: begin
`ifdef BLOOM_INSERT_DUP_DETECT_EN
          bita_set_reg <= bram_rdata[bit_a];
`endif
          bram_en    <= 1'b1;
          bram_we    <= 1'b1;
          bram_wdata <= bram_rdata | mask_a;
          state_reg  <= WR_A;
        end
        WR_A: begin
          // Word B is read only after word A is written, so a shared word sees A's bit.
          bram_en   <= 1'b1;
          bram_we   <= 1'b0;
          bram_addr <= idx_b_reg[HASH_WIDTH-1:BIT_W];
          state_reg <= RD_B;
        end
        RD_B: begin
          bram_en   <= 1'b0;
          state_reg <= WAIT_B;
        end
        WAIT_B: begin
`ifdef BLOOM_INSERT_DUP_DETECT_EN
          bitb_set_reg <= bram_rdata[bit_b];
`endif
          bram_en    <= 1'b1;
          bram_we    <= 1'b1;
          bram_wdata <= bram_rdata | mask_b;
          state_reg  <= WR_B;
        end
        WR_B: begin
          bram_en   <= 1'b0;
          bram_we   <= 1'b0;
          done      <= 1'b1;
          state_reg <= DONE;
`ifdef BLOOM_INSERT_DUP_DETECT_EN
          dup <= bita_set_reg && bitb_set_reg;
          if (!(bita_set_reg && bitb_set_reg))
            insert_count <= count_inc;
`else
          insert_count <= count_inc;
`endif
        end
        DONE: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        CLEAR: begin
          if (bram_addr == LAST_ADDR) begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end else begin
            bram_addr <= bram_addr + ADDR_ONE;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          bram_en   <= 1'b0;
          bram_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
